// File: rtl/alt_vipcti_common_pkg.sv
// Shared definitions for the clocked-video input path: plane limits and helpers.
package alt_vipcti_common_pkg;

  // Largest number of colour planes any sample can carry.
  localparam int MAX_COLOUR_PLANES = 4;

  // Ceiling log2, for sizing counters from a maximum count.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // A requested plane count of zero or beyond the build-time maximum falls
  // back to the maximum, so a bad register write never stalls the packer.
  function automatic int unsigned clamp_planes(input int unsigned requested,
                                               input int unsigned max_planes);
    if (requested == 0 || requested > max_planes) return max_planes;
    return requested;
  endfunction

endpackage

// File: rtl/alt_vipcti_common_plane_tick_counter.sv
// Colour-plane tick counter: turns valid data cycles into sample strobes.
module alt_vipcti_common_plane_tick_counter
  import alt_vipcti_common_pkg::*;
#(
  parameter int NUMBER_OF_COLOUR_PLANES       = 3,
  parameter int COLOUR_PLANES_ARE_IN_PARALLEL = 0,
  parameter int LOG2_NUMBER_OF_COLOUR_PLANES  = 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  sclr,
  input  logic                                  count_cycle,
  input  logic                                  hd_sdn,
  input  logic [LOG2_NUMBER_OF_COLOUR_PLANES:0] active_planes,
  input  logic                                  eol,
  output logic                                  count_sample,
  output logic                                  start_of_sample,
  output logic [LOG2_NUMBER_OF_COLOUR_PLANES-1:0] sample_ticks,
  output logic                                  restart_sample
);

  localparam int TW = LOG2_NUMBER_OF_COLOUR_PLANES;
  localparam int PW = TW + 1;
  localparam logic [PW-1:0] FULL_PLANES = PW'(NUMBER_OF_COLOUR_PLANES);
  localparam logic          PARALLEL    = (COLOUR_PLANES_ARE_IN_PARALLEL != 0);

  logic [PW-1:0] r_planes;
  logic [TW-1:0] r_ticks;
  logic [PW-1:0] w_req_planes;
  logic          w_single;
  logic          w_req_single;
  logic          w_at_last;

  assign w_req_planes = PW'(clamp_planes(32'(active_planes), 32'(NUMBER_OF_COLOUR_PLANES)));

  // One plane per sample in HD or parallel mode, else the count latched at line start.
  assign w_single     = hd_sdn | PARALLEL | (r_planes == PW'(1));
  // Plane count that applies from a clear onwards (the value being relatched).
  assign w_req_single = hd_sdn | PARALLEL | (w_req_planes == PW'(1));
  assign w_at_last    = w_single | ({1'b0, r_ticks} == (r_planes - PW'(1)));

  assign count_sample    = count_cycle & w_at_last;
  assign start_of_sample = (r_ticks == '0);
  assign sample_ticks    = r_ticks;
  // A valid cycle during a clear that alone forms a whole sample.
  assign restart_sample  = count_cycle & w_req_single;

  // Latch the plane count at line boundaries and step the plane index per valid cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_planes <= FULL_PLANES;
      r_ticks  <= '0;
    end else begin
      if (sclr || eol) r_planes <= w_req_planes;
      if (sclr) begin
        r_ticks <= (count_cycle && !w_req_single) ? TW'(1) : '0;
      end else if (eol || w_single) begin
        r_ticks <= '0;
      end else if (count_cycle) begin
        r_ticks <= w_at_last ? '0 : r_ticks + TW'(1);
      end
    end
  end

endmodule

// File: rtl/alt_vipcti_common_sample_position_counter.sv
// Sample/line position tracking and active width/height measurement.
module alt_vipcti_common_sample_position_counter
  import alt_vipcti_common_pkg::*;
#(
  parameter int NUMBER_OF_COLOUR_PLANES       = 3,
  parameter int COLOUR_PLANES_ARE_IN_PARALLEL = 0,
  parameter int LOG2_NUMBER_OF_COLOUR_PLANES  = 2,
  parameter int X_BITS                        = 12,
  parameter int Y_BITS                        = 12
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    sclr,
  input  logic                                    count_cycle,
  input  logic                                    hd_sdn,
  input  logic [LOG2_NUMBER_OF_COLOUR_PLANES:0]   active_planes,
  input  logic                                    eol,
  input  logic                                    eof,
  output logic                                    count_sample,
  output logic                                    start_of_sample,
  output logic [LOG2_NUMBER_OF_COLOUR_PLANES-1:0] sample_ticks,
  output logic [X_BITS-1:0]                       sample_x,
  output logic [Y_BITS-1:0]                       line_y,
  output logic                                    x_overflow,
  output logic [X_BITS-1:0]                       line_width,
  output logic [Y_BITS-1:0]                       frame_height,
  output logic                                    width_valid,
  output logic                                    width_changed
);

  logic              w_count_sample;
  logic              w_restart_sample;
  logic [X_BITS-1:0] r_sample_x;
  logic [Y_BITS-1:0] r_line_y;
  logic              r_x_overflow;
  logic [X_BITS-1:0] r_line_width;
  logic [Y_BITS-1:0] r_frame_height;
  logic              r_width_valid;
  logic              r_width_changed;
  logic              r_width_seen;
  logic              w_x_full;
  logic [X_BITS-1:0] w_final_x;
  logic [Y_BITS-1:0] w_line_y_inc;

  function automatic logic [Y_BITS-1:0] sat_inc_y(input logic [Y_BITS-1:0] v);
    return (&v) ? v : v + Y_BITS'(1);
  endfunction

  alt_vipcti_common_plane_tick_counter #(
    .NUMBER_OF_COLOUR_PLANES      (NUMBER_OF_COLOUR_PLANES),
    .COLOUR_PLANES_ARE_IN_PARALLEL(COLOUR_PLANES_ARE_IN_PARALLEL),
    .LOG2_NUMBER_OF_COLOUR_PLANES (LOG2_NUMBER_OF_COLOUR_PLANES)
  ) u_ticks (
    .clk            (clk),
    .rst_n          (rst_n),
    .sclr           (sclr),
    .count_cycle    (count_cycle),
    .hd_sdn         (hd_sdn),
    .active_planes  (active_planes),
    .eol            (eol),
    .count_sample   (w_count_sample),
    .start_of_sample(start_of_sample),
    .sample_ticks   (sample_ticks),
    .restart_sample (w_restart_sample)
  );

  assign w_x_full     = &r_sample_x;
  // Width seen at eol includes a sample completing in the eol cycle itself.
  assign w_final_x    = (w_count_sample && !w_x_full) ? r_sample_x + X_BITS'(1) : r_sample_x;
  assign w_line_y_inc = sat_inc_y(r_line_y);

  // Position counters, measurements and one-cycle report pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sample_x      <= '0;
      r_line_y        <= '0;
      r_x_overflow    <= 1'b0;
      r_line_width    <= '0;
      r_frame_height  <= '0;
      r_width_valid   <= 1'b0;
      r_width_changed <= 1'b0;
      r_width_seen    <= 1'b0;
    end else if (sclr) begin
      r_sample_x      <= {{(X_BITS-1){1'b0}}, w_restart_sample};
      r_line_y        <= '0;
      r_x_overflow    <= 1'b0;
      r_width_valid   <= 1'b0;
      r_width_changed <= 1'b0;
      r_width_seen    <= 1'b0;
    end else if (eol) begin
      r_line_width    <= w_final_x;
      r_width_valid   <= 1'b1;
      // No previous width to compare against on the first line after a clear.
      r_width_changed <= r_width_seen && (w_final_x != r_line_width);
      r_width_seen    <= 1'b1;
      r_sample_x      <= '0;
      r_x_overflow    <= 1'b0;
      if (eof) begin
        r_frame_height <= w_line_y_inc;
        r_line_y       <= '0;
      end else begin
        r_line_y       <= w_line_y_inc;
      end
    end else begin
      r_width_valid   <= 1'b0;
      r_width_changed <= 1'b0;
      if (w_count_sample) begin
        if (w_x_full) r_x_overflow <= 1'b1;
        else          r_sample_x   <= r_sample_x + X_BITS'(1);
      end
    end
  end

  assign count_sample  = w_count_sample;
  assign sample_x      = r_sample_x;
  assign line_y        = r_line_y;
  assign x_overflow    = r_x_overflow;
  assign line_width    = r_line_width;
  assign frame_height  = r_frame_height;
  assign width_valid   = r_width_valid;
  assign width_changed = r_width_changed;

endmodule

// File: tb/tb_alt_vipcti_common_sample_position_counter.sv
// Self-checking bench for the sample/line position counter.
module tb_alt_vipcti_common_sample_position_counter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclr = 1'b0;
  logic        count_cycle = 1'b0;
  logic        hd_sdn = 1'b0;
  logic [2:0]  active_planes = 3'd3;
  logic        eol = 1'b0;
  logic        eof = 1'b0;

  logic        count_sample, start_of_sample, x_overflow, width_valid, width_changed;
  logic [1:0]  sample_ticks;
  logic [11:0] sample_x, line_y, line_width, frame_height;

  logic        x3_count_sample, x3_start_of_sample, x3_x_overflow, x3_width_valid, x3_width_changed;
  logic [1:0]  x3_sample_ticks;
  logic [2:0]  x3_sample_x, x3_line_width;
  logic [11:0] x3_line_y, x3_frame_height;

  int n_cmp = 0;
  int n_fail = 0;
  bit q_cs[$];
  int q_tk[$];

  always #5 clk = ~clk;

  alt_vipcti_common_sample_position_counter dut (
    .clk(clk), .rst_n(rst_n), .sclr(sclr), .count_cycle(count_cycle), .hd_sdn(hd_sdn),
    .active_planes(active_planes), .eol(eol), .eof(eof),
    .count_sample(count_sample), .start_of_sample(start_of_sample), .sample_ticks(sample_ticks),
    .sample_x(sample_x), .line_y(line_y), .x_overflow(x_overflow), .line_width(line_width),
    .frame_height(frame_height), .width_valid(width_valid), .width_changed(width_changed)
  );

  alt_vipcti_common_sample_position_counter #(.X_BITS(3)) dut_x3 (
    .clk(clk), .rst_n(rst_n), .sclr(sclr), .count_cycle(count_cycle), .hd_sdn(hd_sdn),
    .active_planes(active_planes), .eol(eol), .eof(eof),
    .count_sample(x3_count_sample), .start_of_sample(x3_start_of_sample), .sample_ticks(x3_sample_ticks),
    .sample_x(x3_sample_x), .line_y(x3_line_y), .x_overflow(x3_x_overflow), .line_width(x3_line_width),
    .frame_height(x3_frame_height), .width_valid(x3_width_valid), .width_changed(x3_width_changed)
  );

  // Apply one cycle of inputs away from the rising edge; outputs settle 1ns later.
  task automatic step(input bit cc, input bit e, input bit f, input bit s);
    @(negedge clk);
    count_cycle = cc; eol = e; eof = f; sclr = s;
    #1;
  endtask

  // Drive one valid cycle whose expected strobe/tick go through the scoreboard.
  task automatic drive_cc(input bit exp_cs, input int exp_tk, input string tag);
    bit e_cs;
    int e_tk;
    q_cs.push_back(exp_cs);
    q_tk.push_back(exp_tk);
    step(1, 0, 0, 0);
    e_cs = q_cs.pop_front();
    e_tk = q_tk.pop_front();
    n_cmp++; if (count_sample !== e_cs) begin n_fail++; $display("FAIL %s count_sample: got %0b, expected %0b", tag, count_sample, e_cs); end
    n_cmp++; if (sample_ticks !== e_tk[1:0]) begin n_fail++; $display("FAIL %s sample_ticks: got %0d, expected %0d", tag, sample_ticks, e_tk); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if ({sample_x, line_y, line_width, frame_height} !== 48'd0) begin n_fail++; $display("FAIL reset_counters: got %h, expected 0", {sample_x, line_y, line_width, frame_height}); end
    n_cmp++; if ({x_overflow, width_valid, width_changed, count_sample} !== 4'd0) begin n_fail++; $display("FAIL reset_flags: got %b, expected 0000", {x_overflow, width_valid, width_changed, count_sample}); end
    n_cmp++; if (sample_ticks !== 2'd0 || start_of_sample !== 1'b1) begin n_fail++; $display("FAIL reset_ticks: got ticks=%0d sos=%0b, expected 0/1", sample_ticks, start_of_sample); end
    @(negedge clk); rst_n = 1'b1;
    // Not latched yet: the reset plane count of 3 must still apply.
    active_planes = 3'd2;
    drive_cc(0, 0, "reset_planes");
    drive_cc(0, 1, "reset_planes");
    drive_cc(1, 2, "reset_planes");
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    n_cmp++; if (line_width !== 12'd1 || width_valid !== 1'b1) begin n_fail++; $display("FAIL reset_line_width: got %0d/%0b, expected 1/1", line_width, width_valid); end
  endtask

  task automatic test_basic();
    active_planes = 3'd3;
    step(0, 0, 0, 1);
    for (int i = 0; i < 9; i++) begin
      drive_cc(i % 3 == 2, i % 3, "basic");
      n_cmp++; if (start_of_sample !== (i % 3 == 0)) begin n_fail++; $display("FAIL basic_sos[%0d]: got %0b, expected %0b", i, start_of_sample, i % 3 == 0); end
    end
    step(0, 1, 0, 0);
    n_cmp++; if (sample_x !== 12'd3) begin n_fail++; $display("FAIL basic_sample_x: got %0d, expected 3", sample_x); end
    step(0, 0, 0, 0);
    n_cmp++; if (width_valid !== 1'b1 || line_width !== 12'd3) begin n_fail++; $display("FAIL basic_width: got %0b/%0d, expected 1/3", width_valid, line_width); end
    n_cmp++; if (sample_x !== 12'd0 || line_y !== 12'd1) begin n_fail++; $display("FAIL basic_after_eol: got x=%0d y=%0d, expected 0/1", sample_x, line_y); end
    step(0, 0, 0, 0);
    n_cmp++; if (width_valid !== 1'b0) begin n_fail++; $display("FAIL basic_width_valid_pulse: got %0b, expected 0", width_valid); end
  endtask

  task automatic test_plane_change();
    active_planes = 3'd3;
    step(0, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) active_planes = 3'd2;
      drive_cc(i % 3 == 2, i % 3, "midline_planes");
    end
    step(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive_cc(i % 2 == 1, i % 2, "new_planes");
      if (i == 0) begin
        n_cmp++; if (line_width !== 12'd2) begin n_fail++; $display("FAIL plane_change_width1: got %0d, expected 2", line_width); end
      end
    end
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    n_cmp++; if (line_width !== 12'd2 || width_changed !== 1'b0) begin n_fail++; $display("FAIL plane_change_width2: got %0d/%0b, expected 2/0", line_width, width_changed); end
  endtask

  task automatic test_hd();
    hd_sdn = 1'b1;
    step(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) drive_cc(1, 0, "hd");
    step(0, 0, 0, 0);
    n_cmp++; if (sample_x !== 12'd5) begin n_fail++; $display("FAIL hd_sample_x: got %0d, expected 5", sample_x); end
    step(0, 1, 0, 0);
  endtask

  task automatic test_saturate();
    hd_sdn = 1'b1;
    step(0, 0, 0, 1);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    n_cmp++; if (x3_sample_x !== 3'd7 || x3_x_overflow !== 1'b1) begin n_fail++; $display("FAIL sat_pre_eol: got x=%0d ovf=%0b, expected 7/1", x3_sample_x, x3_x_overflow); end
    n_cmp++; if (sample_x !== 12'd10 || x_overflow !== 1'b0) begin n_fail++; $display("FAIL wide_no_sat: got x=%0d ovf=%0b, expected 10/0", sample_x, x_overflow); end
    step(0, 0, 0, 0);
    n_cmp++; if (x3_line_width !== 3'd7 || x3_width_valid !== 1'b1) begin n_fail++; $display("FAIL sat_width: got %0d/%0b, expected 7/1", x3_line_width, x3_width_valid); end
    n_cmp++; if (x3_x_overflow !== 1'b0 || x3_sample_x !== 3'd0) begin n_fail++; $display("FAIL sat_clear: got ovf=%0b x=%0d, expected 0/0", x3_x_overflow, x3_sample_x); end
  endtask

  task automatic test_widths();
    int widths[3] = '{4, 4, 5};
    bit chg[3] = '{1'b0, 1'b0, 1'b1};
    hd_sdn = 1'b1;
    step(0, 0, 0, 1);
    for (int l = 0; l < 3; l++) begin
      for (int j = 0; j < widths[l] - 1; j++) step(1, 0, (l == 0 && j == 0), 0);
      step(1, 1, (l == 2), 0);
      step(0, 0, 0, 0);
      n_cmp++; if (line_width !== 12'(widths[l]) || width_valid !== 1'b1) begin n_fail++; $display("FAIL widths_line%0d: got %0d/%0b, expected %0d/1", l, line_width, width_valid, widths[l]); end
      n_cmp++; if (width_changed !== chg[l]) begin n_fail++; $display("FAIL widths_changed%0d: got %0b, expected %0b", l, width_changed, chg[l]); end
      if (l == 0) begin
        n_cmp++; if (line_y !== 12'd1 || frame_height !== 12'd0) begin n_fail++; $display("FAIL widths_eof_alone: got y=%0d h=%0d, expected 1/0", line_y, frame_height); end
      end
    end
    n_cmp++; if (frame_height !== 12'd3 || line_y !== 12'd0) begin n_fail++; $display("FAIL widths_frame: got h=%0d y=%0d, expected 3/0", frame_height, line_y); end
  endtask

  task automatic test_back_to_back();
    hd_sdn = 1'b1;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    n_cmp++; if (line_width !== 12'd2 || width_changed !== 1'b1 || width_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_first: got %0d/%0b/%0b, expected 2/1/1", line_width, width_changed, width_valid); end
    step(0, 0, 0, 0);
    n_cmp++; if (line_width !== 12'd0 || width_changed !== 1'b1 || width_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_second: got %0d/%0b/%0b, expected 0/1/1", line_width, width_changed, width_valid); end
    n_cmp++; if (line_y !== 12'd2) begin n_fail++; $display("FAIL b2b_line_y: got %0d, expected 2", line_y); end
    step(0, 0, 0, 0);
    n_cmp++; if (width_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_pulse_end: got %0b, expected 0", width_valid); end
  endtask

  task automatic test_sclr_mid();
    hd_sdn = 1'b0;
    active_planes = 3'd3;
    step(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) drive_cc(i == 2, i, "sclr_line");
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    n_cmp++; if (sample_ticks !== 2'd2) begin n_fail++; $display("FAIL sclr_pre_ticks: got %0d, expected 2", sample_ticks); end
    step(0, 0, 0, 0);
    n_cmp++; if (sample_ticks !== 2'd1 || sample_x !== 12'd0) begin n_fail++; $display("FAIL sclr_restart: got ticks=%0d x=%0d, expected 1/0", sample_ticks, sample_x); end
    n_cmp++; if (line_width !== 12'd1 || line_y !== 12'd0) begin n_fail++; $display("FAIL sclr_retain: got w=%0d y=%0d, expected 1/0", line_width, line_y); end
    drive_cc(0, 1, "sclr_after");
    drive_cc(1, 2, "sclr_after");
  endtask

  task automatic test_clamp();
    hd_sdn = 1'b0;
    active_planes = 3'd0;
    step(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) drive_cc(i == 2, i, "clamp_zero");
    active_planes = 3'd1;
    step(0, 1, 0, 0);
    drive_cc(1, 0, "planes_one");
    drive_cc(1, 0, "planes_one");
    active_planes = 3'd7;
    step(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) drive_cc(i == 2, i, "clamp_high");
    step(0, 1, 0, 0);
  endtask

  task automatic test_reset_midline();
    hd_sdn = 1'b0;
    active_planes = 3'd3;
    step(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    n_cmp++; if (sample_x !== 12'd1 || sample_ticks !== 2'd1) begin n_fail++; $display("FAIL midline_pre: got x=%0d ticks=%0d, expected 1/1", sample_x, sample_ticks); end
    @(negedge clk); rst_n = 1'b0;
    #1;
    n_cmp++; if (sample_x !== 12'd0 || sample_ticks !== 2'd0) begin n_fail++; $display("FAIL async_reset: got x=%0d ticks=%0d, expected 0/0", sample_x, sample_ticks); end
    @(negedge clk); rst_n = 1'b1;
    step(0, 0, 0, 0);
    n_cmp++; if (width_valid !== 1'b0 || line_width !== 12'd0 || frame_height !== 12'd0) begin n_fail++; $display("FAIL midline_abort: got v=%0b w=%0d h=%0d, expected 0/0/0", width_valid, line_width, frame_height); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_plane_change();
    test_hd();
    test_saturate();
    test_widths();
    test_back_to_back();
    test_sclr_mid();
    test_clamp();
    test_reset_midline();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alt_vipcti_common_sample_position_counter.md
# alt_vipcti_common_sample_position_counter

Generalised colour-plane tick, sample and line-position counter for the clocked-video input path. It sits between the sync decoder and the output packer. It converts valid data cycles into sample strobes, with a plane count that is selectable at run time. It also tracks the sample position within a line and the line index within a frame, and measures active width and height so the control slave can report resolution changes.

## Interface
Parameters:
- NUMBER_OF_COLOUR_PLANES, 3: maximum planes per sample, 1..4.
- COLOUR_PLANES_ARE_IN_PARALLEL, 0: 1 means every valid cycle carries a full sample.
- LOG2_NUMBER_OF_COLOUR_PLANES, 2: tick counter width, at least 1.
- X_BITS, 12: width of the sample-position and measured-width counters.
- Y_BITS, 12: width of the line-index and measured-height counters.

Ports (clock and reset first):
- clk, in, 1: single clock.
- rst_n, in, 1: reset, asynchronous and active-low.
- sclr, in, 1: synchronous clear; highest priority.
- count_cycle, in, 1: valid data cycle.
- hd_sdn, in, 1: 1 means HD mode, where every valid cycle is one sample.
- active_planes, in, LOG2_NUMBER_OF_COLOUR_PLANES+1: run-time planes per sample.
- eol, in, 1: end-of-line strobe, aligned with the last valid cycle or later.
- eof, in, 1: end-of-frame strobe; only meaningful together with eol.
- count_sample, out, 1: the current cycle completes a sample.
- start_of_sample, out, 1: the current tick is the first plane of a sample.
- sample_ticks, out, LOG2_NUMBER_OF_COLOUR_PLANES: current plane index.
- sample_x, out, X_BITS: number of samples completed so far in the current line.
- line_y, out, Y_BITS: current line index.
- x_overflow, out, 1: sticky flag; the line exceeded 2^X_BITS-1 samples.
- line_width, out, X_BITS: width of the last completed line.
- frame_height, out, Y_BITS: line count of the last completed frame.
- width_valid, out, 1: one-cycle pulse when line_width updates.
- width_changed, out, 1: one-cycle pulse; the new width differs from the previous one.

## Operation
- Effective plane count planes_eff:
  - planes_eff is 1 when hd_sdn=1 or COLOUR_PLANES_ARE_IN_PARALLEL=1.
  - Otherwise planes_eff is the latched active_planes.
  - An active_planes value of 0 or above NUMBER_OF_COLOUR_PLANES is treated as NUMBER_OF_COLOUR_PLANES.
  - active_planes is latched only on sclr or eol, so the plane count never changes mid-line.
- Tick counter:
  - On count_cycle, the tick counter wraps to 0 at planes_eff-1 and otherwise increments.
  - The tick counter is held at 0 while planes_eff=1.
- Combinational outputs:
  - count_sample = count_cycle & (ticks == planes_eff-1).
  - start_of_sample = (ticks == 0).
  - sample_ticks = ticks.
- sample_x:
  - Increments on count_sample.
  - Saturates at all-ones; a count_sample at saturation sets x_overflow.
- On eol:
  - line_width takes the final sample_x, including a count_sample in the same cycle.
  - width_valid pulses.
  - width_changed pulses if line_width differs from the previous value. It never pulses on the first line after reset or sclr.
  - sample_x, the tick counter and x_overflow clear.
  - line_y increments, saturating.
  - A partial sample pending at eol is discarded.
- On eol with eof: frame_height takes line_y+1 and line_y clears.
- eof without eol is ignored.
- sclr:
  - Clears ticks, sample_x, line_y and x_overflow.
  - Relatches active_planes.
  - Keeps line_width and frame_height.
  - A count_cycle in the sclr cycle counts as tick 0 of a new sample: ticks becomes 1, or sample_x becomes 1 if planes_eff=1.

## Timing
- Reset values:
  - All counters, flags and pulses are 0.
  - line_width and frame_height are 0.
  - The latched plane count is NUMBER_OF_COLOUR_PLANES.
- Latency:
  - count_sample, start_of_sample and sample_ticks are combinational, with zero latency.
  - sample_x, line_y, x_overflow, line_width, frame_height, width_valid and width_changed are registered and update one cycle after the causing edge.
- Priority: rst_n, then sclr, then eol/eof, then count_cycle.
- A reset assertion mid-line aborts the line; no width_valid is generated.
- eol in back-to-back cycles: the second line has width 0, and width_changed follows the normal rule.

## Structure
- The shared package alt_vipcti_common_pkg holds:
  - the clog2 function;
  - the maximum plane count (4);
  - the out-of-range plane-clamp rule as a function reused by the packer.
- Sub-module alt_vipcti_common_plane_tick_counter:
  - Contains the tick counter, planes_eff selection and the combinational strobes.
  - Instantiated once.
  - The position and measurement logic stays in the top level.

## Test plan
- N=3, sequential, active_planes=3, 9 count_cycles, then eol → count_sample on cycles 3, 6 and 9; line_width=3; width_valid pulses once.
- active_planes changed from 3 to 2 mid-line → plane count stays 3 until eol; the next line uses 2-cycle samples.
- hd_sdn=1, 5 count_cycles → 5 count_sample pulses; sample_ticks stays 0.
- X_BITS=3, 10 samples, then eol → sample_x saturates at 7; x_overflow=1; line_width=7; x_overflow clears after eol.
- Three lines of widths 4, 4 and 5, with eof on the third eol → width_changed only on the third eol; frame_height=3; line_y=0.
- sclr asserted together with count_cycle mid-sample at ticks=2 → next-cycle ticks=1; sample_x=0; line_width is retained.
